// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single 32-bit data memory / peripheral bus.
// Round-robin by default; define ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_read_acc,
  input  logic        mem_write_acc
);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StWack, StDone} state_e;

  state_e      state_q, state_d;
  logic        id_q, id_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        grant_id;
  logic        sel_write;

`ifdef ARB_FIXED_PRIO_EN
  assign grant_id = ~m0_req;
`else
  // Pointer names the requester granted last; the other one wins a tie.
  logic last_q, last_d;
  assign grant_id = (m0_req && m1_req) ? ~last_q : m1_req;
`endif

  assign sel_write = grant_id ? m1_write : m0_write;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          id_d    = grant_id;
          write_d = sel_write;
          addr_d  = grant_id ? m1_addr : m0_addr;
          wdata_d = grant_id ? m1_wdata : m0_wdata;
          err_d   = 1'b0;
          state_d = sel_write ? StWr : StRd;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = grant_id;
`endif
        end
      end
      StRd: begin
        err_d = ~mem_read_acc;
        if (id_q) begin
          rdata1_d = mem_rdata;
        end else begin
          rdata0_d = mem_rdata;
        end
        state_d = StDone;
      end
      StWr:    state_d = StWack;
      StWack: begin
        err_d   = ~mem_write_acc;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      id_q     <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  // Outputs decode straight from the state register so an async reset clears them at once.
  always_comb begin
    mem_read  = (state_q == StRd);
    mem_write = (state_q == StWr);
    mem_addr  = (mem_read || mem_write) ? addr_q : 32'h0;
    mem_wdata = (mem_read || mem_write) ? wdata_q : 32'h0;
    m0_done   = (state_q == StDone) && !id_q;
    m1_done   = (state_q == StDone) && id_q;
    m0_err    = m0_done && err_q;
    m1_err    = m1_done && err_q;
    m0_rdata  = rdata0_q;
    m1_rdata  = rdata1_q;
  end

  // Direction is latched for completeness of the transaction record.
  logic unused_write;
  assign unused_write = write_q;

endmodule
